// File: rtl/fir_channel_scheduler.sv
// fir_channel_scheduler
// Round-robin front end that shares one fixed-latency, non-stallable FIR
// datapath between NUM_CH sample streams. Each issued sample carries a
// channel tag through a shift register matched to the datapath latency.
// When the result returns, it is routed back to the channel that owns it.
// A sticky error flag is raised whenever the returning valid does not line
// up with the tag that was expected in that cycle.

module fir_channel_scheduler #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CH       = 4,
    parameter int PIPE_LATENCY = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         i_en,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_req_data,
    input  logic [NUM_CH-1:0]            i_req_valid,
    output logic [NUM_CH-1:0]            o_req_ready,
    output logic [DATA_WIDTH-1:0]        o_pipe_data,
    output logic                         o_pipe_valid,
    input  logic [DATA_WIDTH-1:0]        i_pipe_data,
    input  logic                         i_pipe_valid,
    output logic [DATA_WIDTH-1:0]        o_res_data,
    output logic [NUM_CH-1:0]            o_res_valid,
    output logic                         o_busy,
    output logic                         o_err
);

    // Tag width is derived from the channel count and cannot be overridden.
    localparam int CH_W = $clog2(NUM_CH);

    // Round-robin pointer: the first channel considered for the next grant.
    logic [CH_W-1:0]       ptr_q;
    logic [CH_W-1:0]       ptr_d;

    // Issue stage toward the datapath. The issued channel id is kept
    // alongside so that it can be launched into the tag pipeline.
    logic [DATA_WIDTH-1:0] pipeData_q;
    logic [DATA_WIDTH-1:0] pipeData_d;
    logic                  pipeValid_q;
    logic                  pipeValid_d;
    logic [CH_W-1:0]       pipeCh_q;
    logic [CH_W-1:0]       pipeCh_d;

    // Tag pipeline. Entry 0 is the youngest entry, and the last entry is
    // the tag expected back from the datapath in the current cycle.
    logic                  tagValid_q [PIPE_LATENCY];
    logic [CH_W-1:0]       tagCh_q    [PIPE_LATENCY];

    // Result routing and error state.
    logic [DATA_WIDTH-1:0] resData_q;
    logic [DATA_WIDTH-1:0] resData_d;
    logic [NUM_CH-1:0]     resValid_q;
    logic [NUM_CH-1:0]     resValid_d;
    logic                  err_q;
    logic                  err_d;

    // Arbiter results.
    logic                  grantValid;
    logic [CH_W-1:0]       grantCh;
    logic [DATA_WIDTH-1:0] grantData;
    logic [CH_W:0]         scanSum;
    logic [CH_W-1:0]       scanIdx;

    // Tag expected back from the datapath in the current cycle.
    logic                  expValid;
    logic [CH_W-1:0]       expCh;
    logic                  tagAny;

    // Arbiter: scan from the pointer upward with wrap, and take the first valid channel.
    always_comb begin
        grantValid = 1'b0;
        grantCh    = '0;
        grantData  = '0;
        scanSum    = '0;
        scanIdx    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            scanSum = {1'b0, ptr_q} + (CH_W+1)'(i);
            if (scanSum >= (CH_W+1)'(NUM_CH)) begin
                scanSum = scanSum - (CH_W+1)'(NUM_CH);
            end
            scanIdx = scanSum[CH_W-1:0];
            if (!grantValid && i_en && !reset && i_req_valid[scanIdx]) begin
                grantValid = 1'b1;
                grantCh    = scanIdx;
                grantData  = i_req_data[int'(scanIdx)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // One-hot ready for the granted channel. This is all zero when nothing is granted.
    always_comb begin
        o_req_ready = '0;
        if (grantValid) begin
            o_req_ready = NUM_CH'(1) << grantCh;
        end
    end

    // Issue next-state: latch the granted sample and advance the pointer past the winner.
    always_comb begin
        ptr_d       = ptr_q;
        pipeValid_d = grantValid;
        pipeData_d  = pipeData_q;
        pipeCh_d    = pipeCh_q;
        if (grantValid) begin
            pipeData_d = grantData;
            pipeCh_d   = grantCh;
            if (grantCh == CH_W'(NUM_CH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grantCh + CH_W'(1);
            end
        end
    end

    // Return next-state: route matched results, drop unexpected ones, and flag any mismatch.
    always_comb begin
        expValid   = tagValid_q[PIPE_LATENCY-1];
        expCh      = tagCh_q[PIPE_LATENCY-1];
        resValid_d = '0;
        resData_d  = resData_q;
        err_d      = err_q;
        if (expValid && i_pipe_valid) begin
            resValid_d = NUM_CH'(1) << expCh;
            resData_d  = i_pipe_data;
        end
        if (i_pipe_valid != expValid) begin
            err_d = 1'b1;
        end
    end

    // Busy while a sample is being issued or any tag is still in flight.
    always_comb begin
        tagAny = 1'b0;
        for (int i = 0; i < PIPE_LATENCY; i++) begin
            tagAny = tagAny | tagValid_q[i];
        end
        o_busy = pipeValid_q | tagAny;
    end

    // Issue, pointer, result and error registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            pipeData_q  <= '0;
            pipeValid_q <= 1'b0;
            pipeCh_q    <= '0;
            resData_q   <= '0;
            resValid_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            pipeData_q  <= pipeData_d;
            pipeValid_q <= pipeValid_d;
            pipeCh_q    <= pipeCh_d;
            resData_q   <= resData_d;
            resValid_q  <= resValid_d;
            err_q       <= err_d;
        end
    end

    // Tag shift register: capture {o_pipe_valid, issued channel} every cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_LATENCY; i++) begin
                tagValid_q[i] <= 1'b0;
                tagCh_q[i]    <= '0;
            end
        end else begin
            tagValid_q[0] <= pipeValid_q;
            tagCh_q[0]    <= pipeCh_q;
            for (int i = 1; i < PIPE_LATENCY; i++) begin
                tagValid_q[i] <= tagValid_q[i-1];
                tagCh_q[i]    <= tagCh_q[i-1];
            end
        end
    end

    assign o_pipe_data  = pipeData_q;
    assign o_pipe_valid = pipeValid_q;
    assign o_res_data   = resData_q;
    assign o_res_valid  = resValid_q;
    assign o_err        = err_q;

endmodule
